// File: rtl/vga_tile_selector_if.sv
// Button inputs and VGA DAC outputs of the tile selector, bundled as one port.
interface vga_tile_selector_if #(
   parameter int TILE_W = 4
);
   logic              cuadrante;
   logic              reset_color;
   logic              paint;
   logic              hsync;
   logic              vsync;
   logic              n_sync;
   logic              n_blanc;
   logic              n25MHZCLK;
   logic [7:0]        r;
   logic [7:0]        g;
   logic [7:0]        b;
   logic [TILE_W-1:0] cuadrante_actual;

   modport master (
      output cuadrante, reset_color, paint,
      input  hsync, vsync, n_sync, n_blanc, n25MHZCLK, r, g, b, cuadrante_actual
   );

   modport slave (
      input  cuadrante, reset_color, paint,
      output hsync, vsync, n_sync, n_blanc, n25MHZCLK, r, g, b, cuadrante_actual
   );
endinterface

// File: rtl/vga_tile_selector.sv
// VGA timing plus a COLS x ROWS tile grid with a button-driven selection cursor
// and per-tile 2-bit palette colours; drives the video DAC pins directly.
module vga_tile_selector #(
   parameter int H_ACTIVE     = 640,
   parameter int H_FP         = 16,
   parameter int H_SYNC       = 96,
   parameter int H_BP         = 48,
   parameter int V_ACTIVE     = 480,
   parameter int V_FP         = 10,
   parameter int V_SYNC       = 2,
   parameter int V_BP         = 33,
   parameter int COLS         = 3,
   parameter int ROWS         = 3,
   parameter int BORDER       = 4,
   parameter int DEBOUNCE_CYC = 4,
   parameter int TILE_W       = (COLS * ROWS > 1) ? $clog2(COLS * ROWS) : 1
) (
   input logic               clk,
   input logic               reset,
   vga_tile_selector_if.slave bus
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);
   localparam int N_TILES = COLS * ROWS;
   localparam int TW      = H_ACTIVE / COLS;
   localparam int TH      = V_ACTIVE / ROWS;
   localparam int CW      = $clog2(DEBOUNCE_CYC + 1);
   localparam int ADV     = 0;
   localparam int CLR     = 1;
   localparam int PNT     = 2;

   typedef enum logic {DB_WAIT_LOW, DB_ARMED} db_state_e;

   logic              pe_q;
   logic [HW-1:0]     h_cnt_q;
   logic [VW-1:0]     v_cnt_q;
   logic              hsync_q, vsync_q, blank_q;
   logic [23:0]       rgb_q, rgb_d;
   logic [TILE_W-1:0] sel_q;
   logic [1:0]        pal_q [N_TILES];
   logic [2:0]        btn;
   logic [2:0]        press_q, press_d;
   db_state_e         db_state_q [3];
   db_state_e         db_state_d [3];
   logic [CW-1:0]     db_cnt_q [3];
   logic [CW-1:0]     db_cnt_d [3];
   int                hx, vy, col, row, x_lo, x_hi, y_lo, y_hi;
   logic              active, on_border;
   logic [TILE_W-1:0] tile;

   // Pixel enable and raster counters
   always_ff @(posedge clk) begin
      if (reset) begin
         pe_q    <= 1'b0;
         h_cnt_q <= '0;
         v_cnt_q <= '0;
      end else begin
         pe_q <= ~pe_q;
         if (pe_q) begin
            if (h_cnt_q == HW'(H_TOTAL - 1)) begin
               h_cnt_q <= '0;
               v_cnt_q <= (v_cnt_q == VW'(V_TOTAL - 1)) ? '0 : v_cnt_q + 1'b1;
            end else begin
               h_cnt_q <= h_cnt_q + 1'b1;
            end
         end
      end
   end

   // Tile lookup by constant boundary comparators; the last column/row absorbs the remainder.
   always_comb begin
      hx   = int'(h_cnt_q);
      vy   = int'(v_cnt_q);
      col  = 0;
      x_lo = 0;
      for (int k = 1; k < COLS; k++) begin
         if (hx >= k * TW) begin
            col  = k;
            x_lo = k * TW;
         end
      end
      row  = 0;
      y_lo = 0;
      for (int k = 1; k < ROWS; k++) begin
         if (vy >= k * TH) begin
            row  = k;
            y_lo = k * TH;
         end
      end
      x_hi      = (col == COLS - 1) ? H_ACTIVE - 1 : x_lo + TW - 1;
      y_hi      = (row == ROWS - 1) ? V_ACTIVE - 1 : y_lo + TH - 1;
      active    = (hx < H_ACTIVE) && (vy < V_ACTIVE);
      on_border = (hx - x_lo < BORDER) || (x_hi - hx < BORDER) ||
                  (vy - y_lo < BORDER) || (y_hi - vy < BORDER);
      tile      = TILE_W'(row * COLS + col);
   end

   always_comb begin
      rgb_d = 24'h000000;
      if (active) begin
         if (tile == sel_q && on_border) begin
            rgb_d = 24'hFFFFFF;
         end else begin
            case (pal_q[tile])
               2'd0:    rgb_d = 24'h404040;
               2'd1:    rgb_d = 24'hFF0000;
               2'd2:    rgb_d = 24'h00FF00;
               default: rgb_d = 24'h0000FF;
            endcase
         end
      end
   end

   // Video output register, one pixel behind the counters
   always_ff @(posedge clk) begin
      if (reset) begin
         hsync_q <= 1'b1;
         vsync_q <= 1'b1;
         blank_q <= 1'b0;
         rgb_q   <= 24'h000000;
      end else if (pe_q) begin
         hsync_q <= ~((hx >= H_ACTIVE + H_FP) && (hx < H_ACTIVE + H_FP + H_SYNC));
         vsync_q <= ~((vy >= V_ACTIVE + V_FP) && (vy < V_ACTIVE + V_FP + V_SYNC));
         blank_q <= active;
         rgb_q   <= rgb_d;
      end
   end

   assign btn = {bus.paint, bus.reset_color, bus.cuadrante};

   // Debouncers start locked so a button held through reset must be released first.
   always_comb begin
      for (int i = 0; i < 3; i++) begin
         db_state_d[i] = db_state_q[i];
         db_cnt_d[i]   = '0;
         press_d[i]    = 1'b0;
         case (db_state_q[i])
            DB_ARMED: begin
               if (btn[i]) begin
                  if (db_cnt_q[i] == CW'(DEBOUNCE_CYC - 1)) begin
                     press_d[i]    = 1'b1;
                     db_state_d[i] = DB_WAIT_LOW;
                  end else begin
                     db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                  end
               end
            end
            default: begin
               if (!btn[i]) begin
                  if (db_cnt_q[i] == CW'(DEBOUNCE_CYC - 1)) begin
                     db_state_d[i] = DB_ARMED;
                  end else begin
                     db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                  end
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 3; i++) begin
            db_state_q[i] <= DB_WAIT_LOW;
            db_cnt_q[i]   <= '0;
         end
         press_q <= '0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            db_state_q[i] <= db_state_d[i];
            db_cnt_q[i]   <= db_cnt_d[i];
         end
         press_q <= press_d;
      end
   end

   // Selection and colour memory; clear beats paint, paint hits the tile selected before advancing.
   always_ff @(posedge clk) begin
      if (reset) begin
         sel_q <= '0;
         for (int i = 0; i < N_TILES; i++) pal_q[i] <= 2'd0;
      end else begin
         if (press_q[CLR]) begin
            for (int i = 0; i < N_TILES; i++) pal_q[i] <= 2'd0;
         end else if (press_q[PNT]) begin
            pal_q[sel_q] <= pal_q[sel_q] + 2'd1;
         end
         if (press_q[ADV]) begin
            sel_q <= (sel_q == TILE_W'(N_TILES - 1)) ? '0 : sel_q + 1'b1;
         end
      end
   end

   assign bus.hsync            = hsync_q;
   assign bus.vsync            = vsync_q;
   assign bus.n_sync           = 1'b0;
   assign bus.n_blanc          = blank_q;
   assign bus.n25MHZCLK        = pe_q;
   assign bus.r                = rgb_q[23:16];
   assign bus.g                = rgb_q[15:8];
   assign bus.b                = rgb_q[7:0];
   assign bus.cuadrante_actual = sel_q;
endmodule

// File: tb/tb_vga_tile_selector.sv
// Bench for vga_tile_selector on a shrunken raster: every clk edge is compared
// against a pixel-level reference model, plus directed timing and button scenarios.
module tb_vga_tile_selector;
   localparam int HA = 100, HF = 4, HS = 12, HB = 8;
   localparam int VA = 30,  VF = 2, VS = 2,  VB = 3;
   localparam int COLS = 3, ROWS = 3, BORDER = 4, DEB = 4;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;
   localparam int N = COLS * ROWS;
   localparam int TILE_W = (N > 1) ? $clog2(N) : 1;
   localparam int TW = HA / COLS;
   localparam int TH = VA / ROWS;
   localparam int FRAME_CLK = 2 * HT * VT;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_vec = 0;
   int   n_err = 0;

   vga_tile_selector_if #(.TILE_W(TILE_W)) bus ();

   vga_tile_selector #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .COLS(COLS), .ROWS(ROWS), .BORDER(BORDER), .DEBOUNCE_CYC(DEB),
      .TILE_W(TILE_W)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   // Reference model state
   int          m_h, m_v, m_sel, out_h, out_v;
   bit          m_pe;
   int          m_pal [N];
   bit          m_arm [3];
   int          m_hi [3];
   int          m_lo [3];
   bit          m_pend [3];
   bit          e_hs, e_vs, e_bl;
   logic [23:0] e_rgb;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [23:0] pix_rgb(input int h, input int v);
      int col, row, x0, x1, y0, y1, t;
      bit brd;
      if (h >= HA || v >= VA) return 24'h000000;
      col = h / TW;
      if (col > COLS - 1) col = COLS - 1;
      row = v / TH;
      if (row > ROWS - 1) row = ROWS - 1;
      x0 = col * TW;
      x1 = (col == COLS - 1) ? HA - 1 : x0 + TW - 1;
      y0 = row * TH;
      y1 = (row == ROWS - 1) ? VA - 1 : y0 + TH - 1;
      t  = row * COLS + col;
      brd = (h - x0 < BORDER) || (x1 - h < BORDER) || (v - y0 < BORDER) || (y1 - v < BORDER);
      if (t == m_sel && brd) return 24'hFFFFFF;
      case (m_pal[t])
         0:       return 24'h404040;
         1:       return 24'hFF0000;
         2:       return 24'h00FF00;
         default: return 24'h0000FF;
      endcase
   endfunction

   task automatic model_edge(input bit rst, input bit [2:0] bt);
      if (rst) begin
         e_hs = 1'b1; e_vs = 1'b1; e_bl = 1'b0; e_rgb = 24'h0;
         out_h = -1; out_v = -1;
         m_pe = 1'b0; m_h = 0; m_v = 0; m_sel = 0;
         for (int i = 0; i < N; i++) m_pal[i] = 0;
         for (int i = 0; i < 3; i++) begin
            m_arm[i] = 1'b0; m_hi[i] = 0; m_lo[i] = 0; m_pend[i] = 1'b0;
         end
         return;
      end
      if (m_pe) begin
         e_hs  = !(m_h >= HA + HF && m_h < HA + HF + HS);
         e_vs  = !(m_v >= VA + VF && m_v < VA + VF + VS);
         e_bl  = (m_h < HA) && (m_v < VA);
         e_rgb = pix_rgb(m_h, m_v);
         out_h = m_h; out_v = m_v;
         m_h++;
         if (m_h == HT) begin
            m_h = 0;
            m_v = (m_v + 1) % VT;
         end
      end
      m_pe = !m_pe;
      if (m_pend[1]) begin
         for (int i = 0; i < N; i++) m_pal[i] = 0;
      end else if (m_pend[2]) begin
         m_pal[m_sel] = (m_pal[m_sel] + 1) % 4;
      end
      if (m_pend[0]) m_sel = (m_sel + 1) % N;
      // A press needs DEB highs after having seen DEB lows since the previous press or reset.
      for (int i = 0; i < 3; i++) begin
         m_pend[i] = 1'b0;
         if (bt[i]) begin
            m_hi[i]++;
            m_lo[i] = 0;
            if (m_arm[i] && m_hi[i] == DEB) begin
               m_pend[i] = 1'b1;
               m_arm[i]  = 1'b0;
            end
         end else begin
            m_lo[i]++;
            m_hi[i] = 0;
            if (!m_arm[i] && m_lo[i] == DEB) m_arm[i] = 1'b1;
         end
      end
   endtask

   task automatic step(input bit rst, input bit [2:0] bt);
      @(negedge clk);
      reset           = rst;
      bus.cuadrante   = bt[0];
      bus.reset_color = bt[1];
      bus.paint       = bt[2];
      @(posedge clk);
      #1;
      model_edge(rst, bt);
      check_val("edge", 64'({bus.n25MHZCLK, bus.n_sync, bus.hsync, bus.vsync, bus.n_blanc,
                             bus.r, bus.g, bus.b, bus.cuadrante_actual}),
                64'({m_pe, 1'b0, e_hs, e_vs, e_bl, e_rgb, TILE_W'(m_sel)}));
   endtask

   task automatic hold(input bit [2:0] bt, input int n);
      for (int i = 0; i < n; i++) step(1'b0, bt);
   endtask

   task automatic press(input bit [2:0] bt);
      hold(bt, DEB + 1);
      hold(3'b000, DEB + 2);
   endtask

   task automatic wait_pixel(input int x, input int y);
      int g;
      g = 0;
      while (!(out_h == x && out_v == y) && g < 2 * FRAME_CLK) begin
         step(1'b0, 3'b000);
         g++;
      end
   endtask

   task automatic check_rgb(input string tag, input logic [23:0] exp);
      check_val(tag, 64'({bus.r, bus.g, bus.b}), 64'(exp));
   endtask

   initial begin
      int cnt, w;
      bus.cuadrante = 1'b0; bus.reset_color = 1'b0; bus.paint = 1'b0;

      hold(3'b000, 0);
      step(1'b1, 3'b000);
      step(1'b1, 3'b000);
      check_val("rst_vals", 64'({bus.n25MHZCLK, bus.n_sync, bus.hsync, bus.vsync, bus.n_blanc,
                                 bus.r, bus.g, bus.b, bus.cuadrante_actual}),
                64'({1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 24'h0, TILE_W'(0)}));
      hold(3'b000, 10);

      // Bouncing input never reaches DEB consecutive highs.
      for (int i = 0; i < 1000; i++) step(1'b0, (i % 2 == 0) ? 3'b001 : 3'b000);
      check_val("toggle_sel", 64'(bus.cuadrante_actual), 64'(0));
      hold(3'b000, 1);
      hold(3'b001, DEB + 1);
      check_val("hold4_sel", 64'(bus.cuadrante_actual), 64'(1));
      hold(3'b001, 100);
      check_val("hold100_sel", 64'(bus.cuadrante_actual), 64'(1));
      hold(3'b000, DEB + 2);

      for (int i = 0; i < N; i++) begin
         press(3'b001);
         check_val("wrap_sel", 64'(bus.cuadrante_actual), 64'((i + 2) % N));
      end
      for (int i = 0; i < N - 1; i++) press(3'b001);
      check_val("back_to_0", 64'(bus.cuadrante_actual), 64'(0));

      press(3'b100);
      wait_pixel(1, 1);
      check_rgb("border_1_1", 24'hFFFFFF);
      wait_pixel(20, 5);
      check_rgb("paint_red", 24'hFF0000);
      press(3'b010);
      wait_pixel(20, 5);
      check_rgb("clear_grey", 24'h404040);

      press(3'b100);
      press(3'b110);
      wait_pixel(20, 5);
      check_rgb("clr_beats_paint", 24'h404040);
      wait_pixel(50, 15);
      check_rgb("clr_other_tile", 24'h404040);

      press(3'b101);
      check_val("paint_adv_sel", 64'(bus.cuadrante_actual), 64'(1));
      wait_pixel(1, 1);
      check_rgb("old_tile_edge", 24'hFF0000);
      wait_pixel(20, 5);
      check_rgb("old_tile_red", 24'hFF0000);

      // Mid-frame reset with cuadrante held through it.
      cnt = 0;
      while (m_v != 20 && cnt < 2 * FRAME_CLK) begin
         step(1'b0, 3'b000);
         cnt++;
      end
      step(1'b1, 3'b001);
      check_val("rst_mid", 64'({bus.n25MHZCLK, bus.n_sync, bus.hsync, bus.vsync, bus.n_blanc,
                                bus.r, bus.g, bus.b, bus.cuadrante_actual}),
                64'({1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 24'h0, TILE_W'(0)}));
      cnt = 0;
      do begin
         step(1'b0, (cnt < 10) ? 3'b001 : 3'b000);
         cnt++;
      end while (bus.hsync !== 1'b0 && cnt < 4 * HT);
      check_val("hs_first_fall", 64'(cnt), 64'(2 * (HA + HF) + 2));
      w = 0;
      while (bus.hsync === 1'b0 && w < 4 * HT) begin
         step(1'b0, 3'b000);
         w++;
      end
      check_val("hs_low_clk", 64'(w), 64'(2 * HS));
      while (bus.hsync !== 1'b0 && w < 4 * HT) begin
         step(1'b0, 3'b000);
         w++;
      end
      check_val("hs_period", 64'(w), 64'(2 * HT));
      check_val("held_rst_sel", 64'(bus.cuadrante_actual), 64'(0));

      w = 0;
      while (bus.n_blanc !== 1'b1 && w < 4 * HT) begin
         step(1'b0, 3'b000);
         w++;
      end
      w = 0;
      while (bus.n_blanc === 1'b1 && w < 4 * HT) begin
         step(1'b0, 3'b000);
         w++;
      end
      check_val("blank_high_clk", 64'(w), 64'(2 * HA));

      w = 0;
      while (bus.vsync !== 1'b0 && w < 2 * FRAME_CLK) begin
         step(1'b0, 3'b000);
         w++;
      end
      w = 0;
      while (bus.vsync === 1'b0 && w < 2 * FRAME_CLK) begin
         step(1'b0, 3'b000);
         w++;
      end
      check_val("vs_low_clk", 64'(w), 64'(2 * VS * HT));

      press(3'b001);
      check_val("post_rst_press", 64'(bus.cuadrante_actual), 64'(1));

      // Random button traffic, including bounces and simultaneous presses.
      cnt = 0;
      while (cnt < 10000) begin
         bit [2:0] bt;
         int       len;
         bt  = 3'($urandom);
         len = int'($urandom_range(1, 8));
         hold(bt, len);
         cnt += len;
      end
      hold(3'b000, 2 * HT);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
